// File: rtl/ram_scan_display.sv
// ram_scan_display: scans a 4-nibble page of the 16x4 scratch RAM onto a
// 4-digit common-anode seven-segment display, digit 3 (leftmost) first.
// Each digit slot is REFRESH_DIV cycles long:
//   phase 0 blanks the anodes, phase 1 captures RAM data,
//   phase 2 drives the segments and lights one anode.
// Optional build macro: RAM_SCAN_LZB_EN enables leading-zero blanking.
module ram_scan_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] page,
  output logic [3:0] ab,
  input  logic [3:0] dbo,
  output logic [7:0] display,
  output logic [3:0] anodos
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic [1:0]    dig;
  logic [1:0]    page_q;
  logic [3:0]    nib_q;

  logic slot_end;
  logic frame_end;
  logic ph0;
  logic ph1;
  logic ph2;

  assign slot_end  = (div_cnt == CW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (dig == 2'd0);
  assign ph0       = (div_cnt == CW'(0));
  assign ph1       = (div_cnt == CW'(1));
  assign ph2       = (div_cnt == CW'(2));

  // Read address comes only from registers, so it is stable for the whole slot.
  assign ab = {page_q, dig};

  // Hex to active-low {g,f,e,d,c,b,a}; lowercase b and d.
  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot divider: free-running 0..REFRESH_DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // Digit index steps 3,2,1,0; the page is only taken at the frame boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig    <= 2'd3;
      page_q <= 2'd0;
    end else if (slot_end) begin
      dig <= dig - 2'd1;
      if (dig == 2'd0) begin
        page_q <= page;
      end
    end
  end

  // Capture RAM data once per slot, a full cycle after the address settled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nib_q <= 4'h0;
    end else if (ph1) begin
      nib_q <= dbo;
    end
  end

`ifdef RAM_SCAN_LZB_EN
  logic nz_seen;

  // Display drive with leading-zero blanking on digits 3..1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display <= 8'hFF;
      anodos  <= 4'hF;
      nz_seen <= 1'b0;
    end else begin
      if (frame_end) begin
        nz_seen <= 1'b0;
      end
      if (ph0) begin
        anodos <= 4'hF;
      end else if (ph2) begin
        if ((dig != 2'd0) && (nib_q == 4'h0) && !nz_seen) begin
          display <= 8'hFF;
          anodos  <= 4'hF;
        end else begin
          display <= {1'b1, seg(nib_q)};
          anodos  <= ~(4'b0001 << dig);
          nz_seen <= 1'b1;
        end
      end
    end
  end
`else
  // Display drive: dark in phase 0, lit from phase 2 to the next slot's phase 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display <= 8'hFF;
      anodos  <= 4'hF;
    end else if (ph0) begin
      anodos <= 4'hF;
    end else if (ph2) begin
      display <= {1'b1, seg(nib_q)};
      anodos  <= ~(4'b0001 << dig);
    end
  end
`endif

endmodule

// File: tb/tb_ram_scan_display.sv
// Directed bench for ram_scan_display with REFRESH_DIV=4 and a 16x4 RAM model.
module tb_ram_scan_display;

  logic       clk;
  logic       rst_n;
  logic [1:0] page;
  logic [3:0] ab;
  logic [3:0] dbo;
  logic [7:0] display;
  logic [3:0] anodos;

  logic [3:0] mem [16];

  int checks = 0;
  int passed = 0;
  int failed = 0;

  ram_scan_display #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .page    (page),
    .ab      (ab),
    .dbo     (dbo),
    .display (display),
    .anodos  (anodos)
  );

  assign dbo = mem[ab];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One digit slot starting right before its phase-0 edge.
  // act 1: write RAM[2]=F after the capture edge; act 2: switch page to 1 while lit.
  task automatic do_slot(input string tag, input logic [3:0] exp_ab,
                         input logic [3:0] exp_an, input logic [7:0] exp_disp,
                         input int act);
    tick();
    chk({tag, "_dark"}, {4'h0, anodos}, 8'h0F);
    chk({tag, "_ab"}, {4'h0, ab}, {4'h0, exp_ab});
    tick();
    if (act == 1) mem[2] = 4'hF;
    tick();
    chk({tag, "_an"}, {4'h0, anodos}, {4'h0, exp_an});
    chk({tag, "_disp"}, display, exp_disp);
    if (act == 2) page = 2'd1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    mem[3] = 4'hA; mem[2] = 4'h1; mem[1] = 4'h8; mem[0] = 4'h0;
    page  = 2'd0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();

    // Reset in the middle of a slot.
    rst_n = 1'b0;
    tick();
    chk("rst_disp", display, 8'hFF);
    chk("rst_an", {4'h0, anodos}, 8'h0F);
    chk("rst_ab", {4'h0, ab}, 8'h03);
    rst_n = 1'b1;

    // First slot after release: lit on the third edge.
    tick();
    tick();
    chk("rel_e2_an", {4'h0, anodos}, 8'h0F);
    tick();
    chk("rel_e3_an", {4'h0, anodos}, 8'h07);
    chk("rel_e3_disp", display, 8'h88);
    tick();

    // Rest of frame 1: {A,1,8,0}.
    do_slot("f1_d2", 4'h2, 4'b1011, 8'hF9, 0);
    do_slot("f1_d1", 4'h1, 4'b1101, 8'h80, 0);
    do_slot("f1_d0", 4'h0, 4'b1110, 8'hC0, 0);

    // Frame 2: RAM[2] rewritten after its capture; old value still shown.
    do_slot("f2_d3", 4'h3, 4'b0111, 8'h88, 0);
    do_slot("f2_d2", 4'h2, 4'b1011, 8'hF9, 1);
    do_slot("f2_d1", 4'h1, 4'b1101, 8'h80, 0);
    do_slot("f2_d0", 4'h0, 4'b1110, 8'hC0, 0);

    // Frame 3: the write is now visible.
    for (int i = 4; i < 8; i++) mem[i] = 4'hF;
    do_slot("f3_d3", 4'h3, 4'b0111, 8'h88, 0);
    do_slot("f3_d2", 4'h2, 4'b1011, 8'h8E, 0);
    do_slot("f3_d1", 4'h1, 4'b1101, 8'h80, 0);
    do_slot("f3_d0", 4'h0, 4'b1110, 8'hC0, 0);

    // Frame 4: page switched mid-frame; page 0 data remains until the frame ends.
    do_slot("f4_d3", 4'h3, 4'b0111, 8'h88, 0);
    do_slot("f4_d2", 4'h2, 4'b1011, 8'h8E, 2);
    do_slot("f4_d1", 4'h1, 4'b1101, 8'h80, 0);
    do_slot("f4_d0", 4'h0, 4'b1110, 8'hC0, 0);

    // Frame 5: page 1, all F. Prepare page 0 = {0,0,5,0} and request it back.
    page = 2'd0;
    mem[3] = 4'h0; mem[2] = 4'h0; mem[1] = 4'h5; mem[0] = 4'h0;
    do_slot("f5_d3", 4'h7, 4'b0111, 8'h8E, 0);
    do_slot("f5_d2", 4'h6, 4'b1011, 8'h8E, 0);
    do_slot("f5_d1", 4'h5, 4'b1101, 8'h8E, 0);
    do_slot("f5_d0", 4'h4, 4'b1110, 8'h8E, 0);

    // Frame 6: {0,0,5,0}.
`ifdef RAM_SCAN_LZB_EN
    do_slot("f6_d3", 4'h3, 4'b1111, 8'hFF, 0);
    do_slot("f6_d2", 4'h2, 4'b1111, 8'hFF, 0);
`else
    do_slot("f6_d3", 4'h3, 4'b0111, 8'hC0, 0);
    do_slot("f6_d2", 4'h2, 4'b1011, 8'hC0, 0);
`endif
    do_slot("f6_d1", 4'h1, 4'b1101, 8'h92, 0);
    do_slot("f6_d0", 4'h0, 4'b1110, 8'hC0, 0);

    // Frame 7: all zeros.
    mem[1] = 4'h0;
`ifdef RAM_SCAN_LZB_EN
    do_slot("f7_d3", 4'h3, 4'b1111, 8'hFF, 0);
    do_slot("f7_d2", 4'h2, 4'b1111, 8'hFF, 0);
    do_slot("f7_d1", 4'h1, 4'b1111, 8'hFF, 0);
`else
    do_slot("f7_d3", 4'h3, 4'b0111, 8'hC0, 0);
    do_slot("f7_d2", 4'h2, 4'b1011, 8'hC0, 0);
    do_slot("f7_d1", 4'h1, 4'b1101, 8'hC0, 0);
`endif
    do_slot("f7_d0", 4'h0, 4'b1110, 8'hC0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
